divider_reconstruct_seq: RTL and testbench

Sequential inverse of the 16/8 array divider: accepts a dividend `n`, divisor `d` and the divider's quotient/remainder `q`, `r`, and reconstructs `n' = q*d + r` using an 8-step shift-add datapath. It reports the absolute reconstruction error `|n - n'|` and consistency flags. It sits downstream of the exact or approximate divider arrays in the evaluation harness, where the error output feeds MAE accumulation.

---
 rtl/divider_pkg.sv | 19 +
 rtl/divider_reconstruct_seq_abs_diff.sv | 17 +
 rtl/divider_reconstruct_seq.sv | 155 +++++++++++++++
 tb/tb_divider_reconstruct_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg
// Shared constants and types for the divider evaluation blocks.
//   N_W_DEF   : default dividend / product width
//   D_W_DEF   : default divisor / quotient / remainder width (N_W = 2*D_W)
//   CNT_W_DEF : width of the shift-add step counter for the default D_W
//   recon_state_t : reconstruction FSM states
package divider_pkg;

    localparam int N_W_DEF   = 16;
    localparam int D_W_DEF   = 8;
    localparam int CNT_W_DEF = $clog2(D_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } recon_state_t;

endpackage

// File: rtl/divider_reconstruct_seq_abs_diff.sv
// abs_diff
// Combinational unsigned absolute difference.
//   a, b : unsigned operands, WIDTH bits
//   y    : |a - b|, WIDTH bits
module abs_diff #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = (a >= b) ? (a - b) : (b - a);
    end

endmodule

// File: rtl/divider_reconstruct_seq.sv
// divider_reconstruct_seq
// Rebuilds n' = q*d + r from a divider's quotient/remainder with an
// iterative shift-add multiplier (one quotient bit per cycle) and reports
// the absolute error against the original dividend.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   n, d, q, r           : dividend, divisor, quotient and remainder under test
//   out_valid / out_ready: result handshake (held in DONE until accepted)
//   prod                 : reconstructed q*d + r
//   err                  : |n - prod|
//   exact                : err == 0
//   rem_ge_d             : r >= d (remainder out of range)
module divider_reconstruct_seq
    import divider_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] n,
    input  logic [D_W-1:0] d,
    input  logic [D_W-1:0] q,
    input  logic [D_W-1:0] r,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] prod,
    output logic [N_W-1:0] err,
    output logic           exact,
    output logic           rem_ge_d
);

    localparam int CNT_W = (D_W > 1) ? $clog2(D_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(D_W - 1);

    recon_state_t   state_q,   state_d;
    logic [N_W-1:0] dvd_q,     dvd_d;
    logic [D_W-1:0] dvs_q,     dvs_d;
    logic [D_W-1:0] quo_q,     quo_d;
    logic [D_W-1:0] rem_q,     rem_d;
    logic [N_W-1:0] acc_q,     acc_d;
    logic [N_W-1:0] mcand_q,   mcand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N_W-1:0] prod_q,    prod_d;
    logic [N_W-1:0] err_q,     err_d;
    logic           exact_q,   exact_d;
    logic           rem_bad_q, rem_bad_d;

    logic [N_W-1:0] acc_step;
    logic [N_W-1:0] err_step;

    // Accumulator value after the current step; on the last step this is
    // the final product, so err is taken from it rather than from acc_q.
    assign acc_step = quo_q[cnt_q] ? (acc_q + mcand_q) : acc_q;

    abs_diff #(
        .WIDTH(N_W)
    ) u_abs_diff (
        .a(dvd_q),
        .b(acc_step),
        .y(err_step)
    );

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        err_d     = err_q;
        exact_d   = exact_q;
        rem_bad_d = rem_bad_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = n;
                    dvs_d   = d;
                    quo_d   = q;
                    rem_d   = r;
                    // Seeding the accumulator with r folds the "+ r" into
                    // the multiply at no extra cycle.
                    acc_d   = {{(N_W-D_W){1'b0}}, r};
                    mcand_d = {{(N_W-D_W){1'b0}}, d};
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    prod_d    = acc_step;
                    err_d     = err_step;
                    exact_d   = (err_step == '0);
                    rem_bad_d = (rem_q >= dvs_q);
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            prod_q    <= '0;
            err_q     <= '0;
            exact_q   <= 1'b0;
            rem_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            err_q     <= err_d;
            exact_q   <= exact_d;
            rem_bad_q <= rem_bad_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign prod      = prod_q;
    assign err       = err_q;
    assign exact     = exact_q;
    assign rem_ge_d  = rem_bad_q;

endmodule

// File: tb/tb_divider_reconstruct_seq.sv
// tb_divider_reconstruct_seq
// Scoreboard bench: the driver pushes the arithmetic expectation of each
// accepted operation, the monitor pops and compares on every result
// handshake, and also checks latency, hold-stability and in_ready.
module tb_divider_reconstruct_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;
    logic [15:0] err;
    logic        exact;
    logic        rem_ge_d;

    divider_reconstruct_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .n(n),
        .d(d),
        .q(q),
        .r(r),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .prod(prod),
        .err(err),
        .exact(exact),
        .rem_ge_d(rem_ge_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] prod;
        logic [15:0] err;
        logic        exact;
        logic        ge;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   bp_mode     = 0;
    int   hs_cyc      = -100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int nn, input int dd, input int qq, input int rr);
        exp_t e;
        int   p;
        p       = (qq * dd + rr) % 65536;
        e.prod  = 16'(p);
        e.err   = 16'((nn >= p) ? (nn - p) : (p - nn));
        e.exact = (nn == p);
        e.ge    = (rr >= dd);
        e.acc   = 0;
        return e;
    endfunction

    // Drive one operation; returns right after the accepting edge.
    task automatic send(input int nn, input int dd, input int qq, input int rr, output int acc_cyc);
        exp_t e;
        int   waited;
        @(negedge clk);
        n = 16'(nn); d = 8'(dd); q = 8'(qq); r = 8'(rr);
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            acc_cyc = -1;
        end else begin
            e = model(nn, dd, qq, rr);
            e.acc = cyc + 1;
            acc_cyc = e.acc;
            sb.push_back(e);
            $display("issue n=%0d d=%0d q=%0d r=%0d -> prod=%0d err=%0d", nn, dd, qq, rr, e.prod, e.err);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            // Junk on the operand bus while busy must be ignored.
            n = 16'($urandom); d = 8'($urandom); q = 8'($urandom); r = 8'($urandom);
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Monitor / scoreboard checker.
    initial begin : monitor
        exp_t e;
        exp_t last;
        bit   seen;
        int   bp_cnt;
        seen = 0; bp_cnt = 0;
        last = '{prod: 16'd0, err: 16'd0, exact: 1'b0, ge: 1'b0, acc: 0};
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
                bp_cnt = 0;
                last = '{prod: 16'd0, err: 16'd0, exact: 1'b0, ge: 1'b0, acc: 0};
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                    out_ready = 1'b1;
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen = 1;
                        bp_cnt = 0;
                        chk("latency_cycle", cyc, e.acc + 8);
                    end
                    chk("in_ready_busy", in_ready, 0);
                    chk("prod", prod, e.prod);
                    chk("err", err, e.err);
                    chk("exact", exact, e.exact);
                    chk("rem_ge_d", rem_ge_d, e.ge);
                    if (bp_mode && bp_cnt < 5) begin
                        out_ready = 1'b0;
                        bp_cnt++;
                    end else if (bp_mode) begin
                        out_ready = 1'b1;
                    end else begin
                        out_ready = 1'($urandom_range(0, 1));
                    end
                    if (out_ready) begin
                        $display("result prod=%0d err=%0d exact=%0d rem_ge_d=%0d", prod, err, exact, rem_ge_d);
                        last = e;
                        void'(sb.pop_front());
                        seen = 0;
                        hs_cyc = cyc + 1;
                    end
                end
            end else begin
                // Outputs hold their last result while not presenting one.
                chk("hold_prod", prod, last.prod);
                chk("hold_err", err, last.err);
                if (sb.size() != 0 && cyc > sb[0].acc + 8) begin
                    chk("out_valid_timeout", 0, 1);
                    void'(sb.pop_front());
                end
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin : driver
        int a, b, nn, dd, qq, rr, p, waited;
        rst_n = 1'b0;
        in_valid = 1'b0;
        n = '0; d = '0; q = '0; r = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_prod", prod, 0);
        chk("reset_err", err, 0);
        chk("reset_exact", exact, 0);
        chk("reset_rem_ge_d", rem_ge_d, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        send(1000, 7, 142, 6, a);
        send(1000, 7, 140, 6, a);
        send(16'hFF00, 255, 255, 255, a);
        send(5, 0, 255, 5, a);
        send(0, 0, 0, 0, a);
        drain();

        // Backpressure, then a back-to-back accept right after the handshake.
        bp_mode = 1;
        send(1234, 13, 94, 12, a);
        send(300, 10, 30, 0, b);
        chk("b2b_accept_cycle", b, hs_cyc + 1);
        drain();
        bp_mode = 0;

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            qq = $urandom_range(0, 255);
            dd = $urandom_range(0, 255);
            rr = (dd != 0 && $urandom_range(0, 3) != 0) ? int'($urandom % dd) : $urandom_range(0, 255);
            p  = qq * dd + rr;
            case ($urandom_range(0, 2))
                0: nn = p;
                1: nn = (p + $urandom_range(0, 40) - 20) & 16'hFFFF;
                default: nn = $urandom_range(0, 65535);
            endcase
            send(nn, dd, qq, rr, a);
        end
        drain();

        // Abort an operation with reset during the fourth multiply step.
        send(4321, 99, 43, 64, a);
        waited = 0;
        while (cyc < a + 3 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        rst_n = 1'b0;
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_prod", prod, 0);
        chk("abort_err", err, 0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_result", out_valid, 0);
        send(2000, 17, 117, 11, a);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
